ticket_payment_controller: RTL and testbench

TICKET_PAYMENT_CONTROLLER -- requirements
Module: ticket_payment_controller

---
 rtl/ticket_payment_controller.sv | 176 +++++++++++++++++
 tb/tb_ticket_payment_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ticket_payment_controller.sv
// Ticket payment controller: accepts a fare, collects coins with saturation,
// issues a ticket and returns change, or refunds on cancel or inactivity.
// All outputs come straight from registers updated from the next-state values.
module ticket_payment_controller #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rd,
  input  logic        fare_valid,
  input  logic [15:0] fare,
  output logic        fare_ready,
  input  logic        coin_valid,
  input  logic [1:0]  coin_type,
  input  logic        cancel,
  input  logic        change_ack,
  output logic [15:0] paid_total,
  output logic        ticket_issue,
  output logic        change_valid,
  output logic [15:0] change_amount,
  output logic        refund,
  output logic        coin_reject,
  output logic        fare_err
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    ISSUE   = 3'd2,
    CHANGE  = 3'd3,
    REFUND  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [15:0]   fare_reg, fare_next;
  logic [15:0]   paid_reg, paid_next;
  logic [TW-1:0] tmo_reg, tmo_next;

  logic          fare_ready_reg, fare_ready_next;
  logic          ticket_reg, ticket_next;
  logic          change_valid_reg, change_valid_next;
  logic [15:0]   amount_reg, amount_next;
  logic          refund_reg, refund_next;
  logic          reject_reg, reject_next;
  logic          err_reg, err_next;

  logic [15:0]   coin_value;
  logic [16:0]   coin_sum;
  logic [15:0]   paid_sat;

  // Coin denomination decode.
  always_comb begin
    coin_value = 16'd0;
    case (coin_type)
      2'b00:   coin_value = 16'd5;
      2'b01:   coin_value = 16'd10;
      2'b10:   coin_value = 16'd20;
      default: coin_value = 16'd50;
    endcase
  end

  // One extra bit catches overflow so the running total clamps at 16'hFFFF.
  assign coin_sum = {1'b0, paid_reg} + {1'b0, coin_value};
  assign paid_sat = coin_sum[16] ? 16'hFFFF : coin_sum[15:0];

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_next  = state_reg;
    fare_next   = fare_reg;
    paid_next   = paid_reg;
    tmo_next    = tmo_reg;
    err_next    = 1'b0;
    // Coins only count while collecting; anywhere else they are bounced.
    reject_next = coin_valid && (state_reg != COLLECT);

    unique case (state_reg)
      IDLE: begin
        // fare_ready_reg gates acceptance so nothing is taken in the
        // first cycle after reset, when fare_ready is still low.
        if (fare_valid && fare_ready_reg) begin
          if (fare == 16'd0) begin
            err_next = 1'b1;
          end else begin
            fare_next  = fare;
            paid_next  = 16'd0;
            tmo_next   = '0;
            state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (coin_valid) begin
          paid_next = paid_sat;
          tmo_next  = '0;
        end else if (tmo_reg != TMO_LAST) begin
          tmo_next = tmo_reg + 1'b1;
        end
        // Cancel and timeout both beat reaching the fare; with nothing
        // collected there is nothing to hand back, so skip REFUND.
        if (cancel || (!coin_valid && (tmo_reg == TMO_LAST))) begin
          state_next = (paid_next == 16'd0) ? IDLE : REFUND;
        end else if (paid_next >= fare_reg) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = (paid_reg > fare_reg) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (change_ack && change_valid_reg) state_next = IDLE;
      end
      REFUND: begin
        if (change_ack && change_valid_reg) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are a function of where the machine goes next so that the
    // registered copies line up with the state they describe.
    fare_ready_next   = (state_next == IDLE);
    ticket_next       = (state_next == ISSUE);
    change_valid_next = (state_next == CHANGE) || (state_next == REFUND);
    refund_next       = (state_next == REFUND);
    if (state_next == CHANGE) begin
      amount_next = paid_next - fare_next;
    end else if (state_next == REFUND) begin
      amount_next = paid_next;
    end else begin
      amount_next = 16'd0;
    end
  end

  // State, datapath and output registers; reset discards any transaction.
  always_ff @(posedge clk or posedge rd) begin
    if (rd) begin
      state_reg        <= IDLE;
      fare_reg         <= 16'd0;
      paid_reg         <= 16'd0;
      tmo_reg          <= '0;
      fare_ready_reg   <= 1'b0;
      ticket_reg       <= 1'b0;
      change_valid_reg <= 1'b0;
      amount_reg       <= 16'd0;
      refund_reg       <= 1'b0;
      reject_reg       <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      fare_reg         <= fare_next;
      paid_reg         <= paid_next;
      tmo_reg          <= tmo_next;
      fare_ready_reg   <= fare_ready_next;
      ticket_reg       <= ticket_next;
      change_valid_reg <= change_valid_next;
      amount_reg       <= amount_next;
      refund_reg       <= refund_next;
      reject_reg       <= reject_next;
      err_reg          <= err_next;
    end
  end

  assign fare_ready    = fare_ready_reg;
  assign paid_total    = paid_reg;
  assign ticket_issue  = ticket_reg;
  assign change_valid  = change_valid_reg;
  assign change_amount = amount_reg;
  assign refund        = refund_reg;
  assign coin_reject   = reject_reg;
  assign fare_err      = err_reg;

endmodule

// File: tb/tb_ticket_payment_controller.sv
// Testbench for ticket_payment_controller: reset, a cycle-by-cycle vector
// table, hand-written timeout/reset/saturation sequences, and randomized
// transactions checked against a transaction-level payment model.
module tb_ticket_payment_controller;

  logic        clk = 1'b0;
  logic        rd = 1'b1;
  logic        fare_valid = 1'b0;
  logic [15:0] fare = 16'd0;
  logic        fare_ready;
  logic        coin_valid = 1'b0;
  logic [1:0]  coin_type = 2'd0;
  logic        cancel = 1'b0;
  logic        change_ack = 1'b0;
  logic [15:0] paid_total;
  logic        ticket_issue;
  logic        change_valid;
  logic [15:0] change_amount;
  logic        refund;
  logic        coin_reject;
  logic        fare_err;

  ticket_payment_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .rd            (rd),
    .fare_valid    (fare_valid),
    .fare          (fare),
    .fare_ready    (fare_ready),
    .coin_valid    (coin_valid),
    .coin_type     (coin_type),
    .cancel        (cancel),
    .change_ack    (change_ack),
    .paid_total    (paid_total),
    .ticket_issue  (ticket_issue),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .refund        (refund),
    .coin_reject   (coin_reject),
    .fare_err      (fare_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Observations accumulated across ticks for transaction-level checks.
  int          mon_tickets;
  int          mon_rejects;
  int          mon_errs;
  logic        mon_cv_seen;
  logic [15:0] mon_amt;
  logic        mon_refund;

  typedef struct {
    int fv; int fr; int cv; int ct; int cn; int ack;
    int e_rdy; int e_paid; int e_tk; int e_cv; int e_amt; int e_rf; int e_rj; int e_er;
  } vec_t;

  vec_t vecs[22];
  int   coin_tab[4] = '{5, 10, 20, 50};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [37:0] outs();
    return {fare_ready, paid_total, ticket_issue, change_valid,
            change_amount, refund, coin_reject, fare_err};
  endfunction

  task automatic clear_mon();
    mon_tickets = 0;
    mon_rejects = 0;
    mon_errs    = 0;
    mon_cv_seen = 1'b0;
    mon_amt     = 16'd0;
    mon_refund  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ticket_issue) mon_tickets++;
    if (coin_reject) mon_rejects++;
    if (fare_err) mon_errs++;
    if (change_valid && !mon_cv_seen) begin
      mon_cv_seen = 1'b1;
      mon_amt     = change_amount;
      mon_refund  = refund;
    end
  endtask

  task automatic accept_fare(input logic [15:0] f);
    fare_valid = 1'b1;
    fare       = f;
    tick();
    fare_valid = 1'b0;
    fare       = 16'd0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic early;

    // Exact payment, stray coin, zero fare, ignored ack, overpayment, cancel.
    vecs[0]  = '{1, 40, 0,0,0,0,  0, 0,  0,0,0, 0,0,0};
    vecs[1]  = '{0, 0,  1,2,0,0,  0, 20, 0,0,0, 0,0,0};
    vecs[2]  = '{0, 0,  1,2,0,0,  0, 40, 1,0,0, 0,0,0};
    vecs[3]  = '{0, 0,  0,0,0,0,  1, 40, 0,0,0, 0,0,0};
    vecs[4]  = '{0, 0,  1,3,0,0,  1, 40, 0,0,0, 0,1,0};
    vecs[5]  = '{1, 0,  0,0,0,0,  1, 40, 0,0,0, 0,0,1};
    vecs[6]  = '{0, 0,  0,0,0,0,  1, 40, 0,0,0, 0,0,0};
    vecs[7]  = '{0, 0,  0,0,0,1,  1, 40, 0,0,0, 0,0,0};
    vecs[8]  = '{1, 246,0,0,0,0,  0, 0,  0,0,0, 0,0,0};
    vecs[9]  = '{0, 0,  1,3,0,0,  0, 50, 0,0,0, 0,0,0};
    vecs[10] = '{0, 0,  1,3,0,0,  0, 100,0,0,0, 0,0,0};
    vecs[11] = '{0, 0,  1,3,0,0,  0, 150,0,0,0, 0,0,0};
    vecs[12] = '{0, 0,  1,3,0,0,  0, 200,0,0,0, 0,0,0};
    vecs[13] = '{0, 0,  1,3,0,0,  0, 250,1,0,0, 0,0,0};
    vecs[14] = '{0, 0,  0,0,0,0,  0, 250,0,1,4, 0,0,0};
    vecs[15] = '{0, 0,  1,0,0,0,  0, 250,0,1,4, 0,1,0};
    vecs[16] = '{0, 0,  0,0,0,1,  1, 250,0,0,0, 0,0,0};
    vecs[17] = '{1, 775,0,0,0,0,  0, 0,  0,0,0, 0,0,0};
    vecs[18] = '{0, 0,  1,1,0,0,  0, 10, 0,0,0, 0,0,0};
    vecs[19] = '{0, 0,  1,0,1,0,  0, 15, 0,1,15,1,0,0};
    vecs[20] = '{0, 0,  0,0,0,0,  0, 15, 0,1,15,1,0,0};
    vecs[21] = '{0, 0,  0,0,0,1,  1, 15, 0,0,0, 0,0,0};

    clear_mon();

    // Reset state, then fare_ready rises on the first edge after release.
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 64'(outs()), 64'd0);
    rd = 1'b0;
    tick();
    check("ready after reset", 64'(outs()), 64'({1'b1, 37'd0}));

    // Vector table.
    foreach (vecs[i]) begin
      fare_valid = (vecs[i].fv != 0);
      fare       = 16'(vecs[i].fr);
      coin_valid = (vecs[i].cv != 0);
      coin_type  = 2'(vecs[i].ct);
      cancel     = (vecs[i].cn != 0);
      change_ack = (vecs[i].ack != 0);
      tick();
      check($sformatf("vec[%0d]", i), 64'(outs()),
            64'({vecs[i].e_rdy != 0, 16'(vecs[i].e_paid), vecs[i].e_tk != 0,
                 vecs[i].e_cv != 0, 16'(vecs[i].e_amt), vecs[i].e_rf != 0,
                 vecs[i].e_rj != 0, vecs[i].e_er != 0}));
    end
    fare_valid = 1'b0; fare = 16'd0; coin_valid = 1'b0; coin_type = 2'd0;
    cancel = 1'b0; change_ack = 1'b0;

    // Timeout after a coin: refund appears after exactly 8 coinless cycles.
    clear_mon();
    accept_fare(16'd100);
    coin_valid = 1'b1; coin_type = 2'd3;
    tick();
    coin_valid = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (change_valid) early = 1'b1;
    end
    check("timeout not early", 64'(early), 64'd0);
    tick();
    check("timeout refund", 64'({change_valid, refund, change_amount}), 64'({1'b1, 1'b1, 16'd50}));
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    check("timeout ack idle", 64'({fare_ready, change_valid, paid_total}), 64'({1'b1, 1'b0, 16'd50}));
    check("timeout no ticket", 64'(mon_tickets), 64'd0);

    // Timeout with no coins: straight back to IDLE, no change_valid.
    clear_mon();
    accept_fare(16'd100);
    n = 0;
    while (!fare_ready && n < 20) begin
      tick();
      n++;
    end
    check("empty timeout cycles", 64'(n), 64'd8);
    check("empty timeout no cv", 64'(mon_cv_seen), 64'd0);

    // Mid-transaction reset discards everything.
    clear_mon();
    accept_fare(16'd80);
    coin_valid = 1'b1; coin_type = 2'd3;
    tick();
    coin_valid = 1'b0;
    check("pre-reset paid", 64'(paid_total), 64'd50);
    #2 rd = 1'b1;
    #1;
    check("async reset outputs", 64'(outs()), 64'd0);
    @(posedge clk);
    #1;
    check("held reset outputs", 64'(outs()), 64'd0);
    rd = 1'b0;
    tick();
    check("ready after mid reset", 64'(outs()), 64'({1'b1, 37'd0}));
    repeat (10) tick();
    check("mid reset no ticket/refund", 64'({mon_tickets != 0, mon_cv_seen}), 64'd0);

    // Saturation at 16'hFFFF with a maximal fare.
    clear_mon();
    accept_fare(16'hFFFF);
    coin_valid = 1'b1; coin_type = 2'd3;
    for (int k = 0; k < 1311; k++) tick();
    coin_valid = 1'b0;
    check("saturated paid/ticket", 64'({paid_total, ticket_issue}), 64'({16'hFFFF, 1'b1}));
    tick();
    check("saturated exact -> idle", 64'({fare_ready, mon_cv_seen}), 64'({1'b1, 1'b0}));

    // Randomized transactions against a transaction-level model.
    for (int t = 0; t < 30; t++) begin
      int fare_v, mode, s, n_drive, cut, ack_delay, exp_sum;
      bit with_coin;
      int coins[$];
      logic exp_tk, exp_cv, exp_rf;
      int exp_amt;

      fare_v = $urandom_range(1, 300);
      mode   = $urandom_range(0, 3);
      coins.delete();
      s = 0;
      while (s < fare_v) begin
        coins.push_back($urandom_range(0, 3));
        s += coin_tab[coins[coins.size()-1]];
      end
      with_coin = 1'b0;
      if (mode <= 1) begin
        n_drive = coins.size();
      end else if (mode == 2) begin
        cut       = $urandom_range(0, coins.size() - 1);
        with_coin = ($urandom_range(0, 1) == 1);
        n_drive   = with_coin ? cut + 1 : cut;
      end else begin
        n_drive = coins.size() - 1;
      end
      exp_sum = 0;
      for (int i = 0; i < n_drive; i++) exp_sum += coin_tab[coins[i]];
      if (mode <= 1) begin
        exp_tk  = 1'b1;
        exp_cv  = (exp_sum > fare_v);
        exp_amt = exp_cv ? exp_sum - fare_v : 0;
        exp_rf  = 1'b0;
      end else begin
        exp_tk  = 1'b0;
        exp_cv  = (exp_sum > 0);
        exp_amt = exp_sum;
        exp_rf  = exp_cv;
      end

      clear_mon();
      accept_fare(16'(fare_v));
      for (int i = 0; i < n_drive; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        coin_valid = 1'b1;
        coin_type  = 2'(coins[i]);
        cancel     = (mode == 2) && with_coin && (i == n_drive - 1);
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
      end
      if (mode == 2 && !with_coin) begin
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
      end
      ack_delay = $urandom_range(0, 3);
      n = 0;
      while (!fare_ready && n < 60) begin
        change_ack = 1'b0;
        if (change_valid) begin
          if (ack_delay == 0) change_ack = 1'b1;
          else ack_delay--;
        end
        tick();
        n++;
      end
      change_ack = 1'b0;

      check($sformatf("rnd[%0d] settle", t), 64'(n < 60), 64'd1);
      check($sformatf("rnd[%0d] tickets", t), 64'(mon_tickets), 64'(exp_tk ? 1 : 0));
      check($sformatf("rnd[%0d] change", t), 64'({mon_cv_seen, mon_amt, mon_refund}),
            64'({exp_cv, 16'(exp_amt), exp_rf}));
      check($sformatf("rnd[%0d] paid", t), 64'(paid_total), 64'(16'(exp_sum)));
      check($sformatf("rnd[%0d] no reject/err", t), 64'(mon_rejects + mon_errs), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
